// File: rtl/conv_addr_gen_if.sv
// Request/response bundle for conv_addr_gen: load/advance controls, channel
// bases, and the registered address result.
interface conv_addr_gen_if #(
  parameter int ADDR_W = 7
);
  logic              ld;
  logic              adv;
  logic [1:0]        sel;
  logic              clrX;
  logic [ADDR_W-1:0] xBase;
  logic [ADDR_W-1:0] yBase;
  logic [ADDR_W-1:0] zBase;
  logic [ADDR_W-1:0] adrOut;
  logic              adrValid;
  logic              doneAdr;

  modport master (
    output ld, adv, sel, clrX, xBase, yBase, zBase,
    input  adrOut, adrValid, doneAdr
  );

  modport slave (
    input  ld, adv, sel, clrX, xBase, yBase, zBase,
    output adrOut, adrValid, doneAdr
  );
endinterface

// File: rtl/conv_addr_gen.sv
// Three-channel (ifmap/filter/psum) convolution address generator.
// Define ADDR_GEN_WRAP_EN to reduce addresses and the stepped ifmap base modulo DEPTH.
module conv_addr_gen #(
  parameter int ADDR_W   = 7,
  parameter int ROW_LEN  = 16,
  parameter int STRIDE   = 4,
  parameter int ROWS     = 14,
  parameter int FILT_LEN = 4,
  parameter int PSUM_LEN = 64,
  parameter int DEPTH    = 100
) (
  input logic             clk,
  input logic             rst,
  conv_addr_gen_if.slave  bus
);

`ifdef ADDR_GEN_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  // Without wrapping the modulus is 2^ADDR_W, which reduces to plain truncation.
  localparam int MOD_V = WRAP_EN ? DEPTH : (1 << ADDR_W);
  localparam int CW    = (ROW_LEN  > 1) ? $clog2(ROW_LEN)  : 1;
  localparam int RW    = $clog2(ROWS + 1);
  localparam int FW    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int PW    = (PSUM_LEN > 1) ? $clog2(PSUM_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] xbase_q, xbase_d, ybase_q, ybase_d, zbase_q, zbase_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;

  logic accept, row_wrap, last_row;

  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return ADDR_W'(s % (ADDR_W+1)'(MOD_V));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.ld)        state_d = S_RUN;
    else if (last_row) state_d = S_DONE;
  end

  // ld and clrX both outrank adv, so either one suppresses acceptance.
  always_comb begin
    accept      = (state_q == S_RUN) && bus.adv && (bus.sel != 2'b11) && !bus.ld && !bus.clrX;
    row_wrap    = accept && (bus.sel == 2'b00) && (col_q == CW'(ROW_LEN - 1));
    last_row    = row_wrap && (row_q == RW'(ROWS - 1));
    bus.doneAdr = (state_q == S_DONE);
  end

  always_comb begin
    xbase_d = xbase_q;
    ybase_d = ybase_q;
    zbase_d = zbase_q;
    adr_d   = adr_q;
    valid_d = 1'b0;
    col_d   = col_q;
    row_d   = row_q;
    fcnt_d  = fcnt_q;
    pcnt_d  = pcnt_q;
    if (bus.ld) begin
      xbase_d = bus.xBase;
      ybase_d = bus.yBase;
      zbase_d = bus.zBase;
      col_d   = '0;
      row_d   = '0;
      fcnt_d  = '0;
      pcnt_d  = '0;
    end else if (bus.clrX) begin
      col_d = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      case (bus.sel)
        2'b00: begin
          adr_d = addr_add(xbase_q, ADDR_W'(col_q));
          if (row_wrap) begin
            col_d   = '0;
            row_d   = row_q + 1'b1;
            xbase_d = addr_add(xbase_q, ADDR_W'(STRIDE));
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        2'b01: begin
          adr_d  = addr_add(ybase_q, ADDR_W'(fcnt_q));
          fcnt_d = (fcnt_q == FW'(FILT_LEN - 1)) ? '0 : fcnt_q + 1'b1;
        end
        2'b10: begin
          adr_d  = addr_add(zbase_q, ADDR_W'(pcnt_q));
          pcnt_d = (pcnt_q == PW'(PSUM_LEN - 1)) ? '0 : pcnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xbase_q <= '0;
      ybase_q <= '0;
      zbase_q <= '0;
      adr_q   <= '0;
      valid_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      fcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      xbase_q <= xbase_d;
      ybase_q <= ybase_d;
      zbase_q <= zbase_d;
      adr_q   <= adr_d;
      valid_q <= valid_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fcnt_q  <= fcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign bus.adrOut   = adr_q;
  assign bus.adrValid = valid_q;

endmodule

// File: tb/tb_conv_addr_gen.sv
// Directed, table-driven bench for conv_addr_gen with hand-computed expectations.
module tb_conv_addr_gen;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  conv_addr_gen_if #(.ADDR_W(7)) bus ();

  conv_addr_gen #(
    .ADDR_W  (7),
    .ROW_LEN (16),
    .STRIDE  (4),
    .ROWS    (14),
    .FILT_LEN(4),
    .PSUM_LEN(64),
    .DEPTH   (100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic       adv;
    logic [1:0] sel;
    logic       clrX;
    logic [6:0] xb;
    logic [6:0] yb;
    logic [6:0] zb;
    logic       ev;
    logic [6:0] ea;
    logic       ed;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic l, input logic a, input logic [1:0] s,
                     input logic c, input logic [6:0] xb, input logic [6:0] yb,
                     input logic [6:0] zb, input logic ev, input logic [6:0] ea,
                     input logic ed, input string nm);
    vec_t v;
    v.rst = r; v.ld = l; v.adv = a; v.sel = s; v.clrX = c;
    v.xb = xb; v.yb = yb; v.zb = zb;
    v.ev = ev; v.ea = ea; v.ed = ed; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic l, input logic a, input logic [1:0] s,
                       input logic c, input logic [6:0] xb, input logic [6:0] yb,
                       input logic [6:0] zb);
    rst = r; bus.ld = l; bus.adv = a; bus.sel = s; bus.clrX = c;
    bus.xBase = xb; bus.yBase = yb; bus.zBase = zb;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic ev, input int ea, input logic ed);
    chk({nm, ".valid"}, int'(bus.adrValid), int'(ev));
    chk({nm, ".adr"},   int'(bus.adrOut),   ea);
    chk({nm, ".done"},  int'(bus.doneAdr),  int'(ed));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; bus.ld = 1'b0; bus.adv = 1'b0; bus.sel = 2'b00; bus.clrX = 1'b0;
    bus.xBase = '0; bus.yBase = '0; bus.zBase = '0;
    @(posedge clk);
    #1;

    add(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "reset");
    add(0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "idle_adv");
    add(0, 1, 0, 2'b00, 0, 0, 10, 20, 0, 0, 0, "ld0");
    for (int i = 0; i < 16; i++)
      add(0, 0, 1, 2'b00, 0, 0, 10, 20, 1, 7'(i), 0, "row0");
    add(0, 0, 1, 2'b00, 0, 0, 10, 20, 1, 4, 0, "row1_c0");
    add(0, 0, 1, 2'b00, 0, 0, 10, 20, 1, 5, 0, "row1_c1");
    add(0, 0, 1, 2'b01, 0, 0, 10, 20, 1, 10, 0, "filt0");
    add(0, 0, 1, 2'b01, 0, 0, 10, 20, 1, 11, 0, "filt1");
    add(0, 0, 1, 2'b01, 0, 0, 10, 20, 1, 12, 0, "filt2");
    add(0, 0, 1, 2'b01, 0, 0, 10, 20, 1, 13, 0, "filt3");
    add(0, 0, 1, 2'b01, 0, 0, 10, 20, 1, 10, 0, "filt_wrap");
    add(0, 0, 1, 2'b01, 0, 0, 10, 20, 1, 11, 0, "filt_wrap1");
    add(0, 0, 1, 2'b10, 0, 0, 10, 20, 1, 20, 0, "psum0");
    add(0, 0, 1, 2'b10, 0, 0, 10, 20, 1, 21, 0, "psum1");
    add(0, 0, 1, 2'b10, 0, 0, 10, 20, 1, 22, 0, "psum2");
    add(0, 0, 1, 2'b00, 0, 0, 10, 20, 1, 6, 0, "ifmap_resume");
    add(0, 0, 1, 2'b11, 0, 0, 10, 20, 0, 6, 0, "sel_none");
    add(0, 0, 0, 2'b00, 1, 0, 10, 20, 0, 6, 0, "clrx_only");
    add(0, 0, 1, 2'b00, 0, 0, 10, 20, 1, 4, 0, "after_clrx");
    add(0, 1, 0, 2'b00, 0, 30, 10, 20, 0, 4, 0, "ld30");
    for (int i = 0; i < 5; i++)
      add(0, 0, 1, 2'b00, 0, 30, 10, 20, 1, 7'(30 + i), 0, "x30");
    add(0, 0, 1, 2'b00, 1, 30, 10, 20, 0, 34, 0, "clrx_adv");
    add(0, 0, 1, 2'b00, 0, 30, 10, 20, 1, 30, 0, "post_clrx");
    add(0, 1, 1, 2'b00, 0, 50, 10, 20, 0, 30, 0, "ld_adv");
    add(0, 0, 1, 2'b00, 0, 50, 10, 20, 1, 50, 0, "post_ld");
    add(0, 0, 1, 2'b01, 0, 50, 10, 20, 1, 10, 0, "filt_cleared");
    add(0, 0, 1, 2'b10, 0, 50, 10, 20, 1, 20, 0, "psum_cleared");

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].adv, vecs[i].sel, vecs[i].clrX,
            vecs[i].xb, vecs[i].yb, vecs[i].zb);
      chk_out(vecs[i].nm, vecs[i].ev, int'(vecs[i].ea), vecs[i].ed);
    end

    // Full sweep: 14 rows of 16, base steps by 4 per row.
    drive(0, 1, 0, 2'b00, 0, 0, 0, 0);
    chk("sweep_ld.done", int'(bus.doneAdr), 0);
    for (int k = 0; k < 224; k++) begin
      drive(0, 0, 1, 2'b00, 0, 0, 0, 0);
      chk("sweep.valid", int'(bus.adrValid), 1);
      chk("sweep.adr", int'(bus.adrOut), (k / 16) * 4 + (k % 16));
      chk("sweep.done", int'(bus.doneAdr), (k == 223) ? 1 : 0);
    end
    drive(0, 0, 1, 2'b00, 0, 0, 0, 0);
    chk_out("done_adv", 0, 67, 1);
    drive(0, 1, 0, 2'b00, 0, 0, 0, 0);
    chk("done_ld.done", int'(bus.doneAdr), 0);
    drive(0, 0, 1, 2'b00, 0, 0, 0, 0);
    chk_out("rerun", 1, 0, 0);

`ifdef ADDR_GEN_WRAP_EN
    drive(0, 1, 0, 2'b00, 0, 98, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 2'b00, 0, 98, 0, 0);
      chk("wrap_depth.adr", int'(bus.adrOut), (98 + i) % 100);
    end
`else
    drive(0, 1, 0, 2'b00, 0, 120, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 2'b00, 0, 120, 0, 0);
      chk("wrap_pow2.adr", int'(bus.adrOut), (120 + i) % 128);
    end
`endif

    // Reset landing on column 7 of a row.
    drive(0, 1, 0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      drive(0, 0, 1, 2'b00, 0, 0, 0, 0);
    chk("pre_rst.adr", int'(bus.adrOut), 6);
    drive(1, 0, 1, 2'b00, 0, 0, 0, 0);
    chk_out("mid_rst", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 2'b00, 0, 0, 0, 0);
      chk_out("post_rst_adv", 0, 0, 0);
    end
    drive(0, 1, 0, 2'b00, 0, 5, 0, 0);
    drive(0, 0, 1, 2'b00, 0, 5, 0, 0);
    chk_out("post_rst_ld", 1, 5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
